// File: rtl/ddr_hit_judge_pkg.sv
// Shared constants and types for the DDR hit judge: default sizing, judge codes and FSM states.
package ddr_hit_judge_pkg;

  localparam int DEF_NUM_LANES     = 4;
  localparam int DEF_TICK_W        = 4;
  localparam int DEF_PERFECT_TICKS = 3;
  localparam int DEF_GOOD_TICKS    = 8;
  localparam int DEF_SCORE_W       = 14;
  localparam int DEF_SCORE_MAX     = 9999;
  localparam int DEF_COMBO_W       = 14;
  localparam int DEF_PERFECT_PTS   = 10;
  localparam int DEF_GOOD_PTS      = 5;
  localparam int DEF_COMBO_STEP    = 10;

  typedef enum logic [1:0] {
    JUDGE_MISS    = 2'd0,
    JUDGE_GOOD    = 2'd1,
    JUDGE_PERFECT = 2'd2,
    JUDGE_WRONG   = 2'd3
  } judge_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPEN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_correct(input judge_e j);
    return (j == JUDGE_PERFECT) || (j == JUDGE_GOOD);
  endfunction

endpackage

// File: rtl/ddr_hit_judge_if.sv
// Game-side bus of the hit judge: beat/tick/control inputs, lane buttons and the judgement/score outputs.
interface ddr_hit_judge_if
  import ddr_hit_judge_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int SCORE_W   = DEF_SCORE_W,
  parameter int COMBO_W   = DEF_COMBO_W
);
  logic                 beat_tick;
  logic                 sub_tick;
  logic                 pause;
  logic                 clear;
  logic [NUM_LANES-1:0] arrow_mask;
  logic [NUM_LANES-1:0] btn;
  logic                 judge_valid;
  judge_e               judge_code;
  logic                 correct_hit;
  logic                 incorrect_hit;
  logic [SCORE_W-1:0]   score;
  logic [COMBO_W-1:0]   combo;
  logic [COMBO_W-1:0]   max_combo;

  modport master (
    output beat_tick, sub_tick, pause, clear, arrow_mask, btn,
    input  judge_valid, judge_code, correct_hit, incorrect_hit, score, combo, max_combo
  );

  modport slave (
    input  beat_tick, sub_tick, pause, clear, arrow_mask, btn,
    output judge_valid, judge_code, correct_hit, incorrect_hit, score, combo, max_combo
  );
endinterface

// File: rtl/ddr_hit_judge_btn_sync_edge.sv
// One lane of button input: 2-FF synchroniser followed by a rising-edge detector.
module btn_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);
  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
      prev <= sync;
    end
  end

  assign press = sync & ~prev;
endmodule

// File: rtl/ddr_hit_judge.sv
// Per-beat timing judge: grades each beat's arrow set and keeps saturating score, combo and max combo.
module ddr_hit_judge
  import ddr_hit_judge_pkg::*;
#(
  parameter int NUM_LANES     = DEF_NUM_LANES,
  parameter int TICK_W        = DEF_TICK_W,
  parameter int PERFECT_TICKS = DEF_PERFECT_TICKS,
  parameter int GOOD_TICKS    = DEF_GOOD_TICKS,
  parameter int SCORE_W       = DEF_SCORE_W,
  parameter int SCORE_MAX     = DEF_SCORE_MAX,
  parameter int COMBO_W       = DEF_COMBO_W,
  parameter int PERFECT_PTS   = DEF_PERFECT_PTS,
  parameter int GOOD_PTS      = DEF_GOOD_PTS,
  parameter int COMBO_STEP    = DEF_COMBO_STEP
) (
  input logic             clk,
  input logic             reset_n,
  ddr_hit_judge_if.slave  bus
);
  logic [NUM_LANES-1:0] press;
  state_e               state, state_nx;
  logic [TICK_W-1:0]    tick_cnt, tick_nx;
  logic [NUM_LANES-1:0] pending, pending_nx;
  logic [NUM_LANES-1:0] hit, hit_nx;
  logic [NUM_LANES-1:0] hit_upd;
  logic                 wrong, complete, timeout;
  logic                 judge_fire;
  judge_e               judge_nx;

  logic                 judge_valid_q, correct_q, incorrect_q;
  judge_e               judge_code_q;
  logic [SCORE_W-1:0]   score_q, pts, score_sat;
  logic [SCORE_W+1:0]   score_sum;
  logic [COMBO_W-1:0]   combo_q, max_q, combo_inc, bonus;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    btn_sync_edge u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (bus.btn[i]),
      .press   (press[i])
    );
  end

  assign hit_upd  = hit | (press & pending);
  assign wrong    = |(press & ~pending);
  assign complete = (hit_upd == pending);
  assign timeout  = bus.sub_tick && (tick_cnt == TICK_W'(GOOD_TICKS - 1));

  // Old beat is resolved first; a beat_tick in the same cycle then reloads the window on top of it.
  always_comb begin
    state_nx   = state;
    tick_nx    = tick_cnt;
    pending_nx = pending;
    hit_nx     = hit;
    judge_fire = 1'b0;
    judge_nx   = JUDGE_MISS;
    if (!bus.pause) begin
      if (state == ST_OPEN) begin
        hit_nx = hit_upd;
        if (bus.sub_tick) tick_nx = tick_cnt + 1'b1;
        if (wrong || complete || timeout || bus.beat_tick) begin
          judge_fire = 1'b1;
          state_nx   = ST_DONE;
          if (wrong)
            judge_nx = JUDGE_WRONG;
          else if (complete)
            judge_nx = (tick_cnt < TICK_W'(PERFECT_TICKS)) ? JUDGE_PERFECT : JUDGE_GOOD;
          else
            judge_nx = JUDGE_MISS;
        end
      end
      if (bus.beat_tick) begin
        pending_nx = bus.arrow_mask;
        hit_nx     = '0;
        tick_nx    = '0;
        state_nx   = (bus.arrow_mask != '0) ? ST_OPEN : ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      pending  <= '0;
      hit      <= '0;
    end else if (bus.clear) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      pending  <= '0;
      hit      <= '0;
    end else begin
      state    <= state_nx;
      tick_cnt <= tick_nx;
      pending  <= pending_nx;
      hit      <= hit_nx;
    end
  end

  assign combo_inc = (combo_q == {COMBO_W{1'b1}}) ? combo_q : combo_q + 1'b1;
  assign bonus     = combo_inc / COMBO_W'(COMBO_STEP);
  assign pts       = (judge_nx == JUDGE_PERFECT) ? SCORE_W'(PERFECT_PTS) : SCORE_W'(GOOD_PTS);
  assign score_sum = (SCORE_W+2)'(score_q) + (SCORE_W+2)'(pts) + (SCORE_W+2)'(bonus);
  assign score_sat = (score_sum > (SCORE_W+2)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                           : score_sum[SCORE_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      judge_valid_q <= 1'b0;
      judge_code_q  <= JUDGE_MISS;
      correct_q     <= 1'b0;
      incorrect_q   <= 1'b0;
      score_q       <= '0;
      combo_q       <= '0;
      max_q         <= '0;
    end else if (bus.clear) begin
      judge_valid_q <= 1'b0;
      correct_q     <= 1'b0;
      incorrect_q   <= 1'b0;
      score_q       <= '0;
      combo_q       <= '0;
      max_q         <= '0;
    end else begin
      judge_valid_q <= judge_fire;
      correct_q     <= judge_fire && is_correct(judge_nx);
      incorrect_q   <= judge_fire && !is_correct(judge_nx);
      if (judge_fire) begin
        judge_code_q <= judge_nx;
        if (is_correct(judge_nx)) begin
          combo_q <= combo_inc;
          score_q <= score_sat;
          if (combo_inc > max_q) max_q <= combo_inc;
        end else begin
          combo_q <= '0;
        end
      end
    end
  end

  assign bus.judge_valid   = judge_valid_q;
  assign bus.judge_code    = judge_code_q;
  assign bus.correct_hit   = correct_q;
  assign bus.incorrect_hit = incorrect_q;
  assign bus.score         = score_q;
  assign bus.combo         = combo_q;
  assign bus.max_combo     = max_q;
endmodule

// File: tb/tb_ddr_hit_judge.sv
// Directed bench for ddr_hit_judge: a reference scoring model pushes expected judgements, a monitor pops them.
module tb_ddr_hit_judge;
  import ddr_hit_judge_pkg::*;

  localparam int C_MISS = 0, C_GOOD = 1, C_PERFECT = 2, C_WRONG = 3;

  typedef struct {
    int code;
    int score;
    int combo;
    int max_combo;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ddr_hit_judge_if bus ();

  ddr_hit_judge dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   m_score = 0, m_combo = 0, m_max = 0;
  int   guard;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference scoring model: updates the expected totals and queues the judgement.
  task automatic expect_judge(input int code);
    exp_t e;
    if (code == C_PERFECT || code == C_GOOD) begin
      if (m_combo < 16383) m_combo++;
      m_score = m_score + ((code == C_PERFECT) ? 10 : 5) + m_combo / 10;
      if (m_score > 9999) m_score = 9999;
      if (m_combo > m_max) m_max = m_combo;
    end else begin
      m_combo = 0;
    end
    e.code = code; e.score = m_score; e.combo = m_combo; e.max_combo = m_max;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (bus.judge_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_judge", bus.judge_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        check("judge_code", bus.judge_code, mon_e.code);
        check("correct_hit", bus.correct_hit, (mon_e.code == C_PERFECT || mon_e.code == C_GOOD));
        check("incorrect_hit", bus.incorrect_hit, (mon_e.code == C_MISS || mon_e.code == C_WRONG));
        check("score", bus.score, mon_e.score);
        check("combo", bus.combo, mon_e.combo);
        check("max_combo", bus.max_combo, mon_e.max_combo);
      end
    end else if ((bus.correct_hit | bus.incorrect_hit) !== 1'b0) begin
      check("stray_hit", {bus.correct_hit, bus.incorrect_hit}, 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus_beat(input logic [3:0] mask);
    bus.arrow_mask = mask;
    bus.beat_tick  = 1'b1;
    step(1);
    bus.beat_tick  = 1'b0;
  endtask

  task automatic subs(input int n);
    repeat (n) begin
      bus.sub_tick = 1'b1;
      step(1);
      bus.sub_tick = 1'b0;
    end
  endtask

  task automatic press(input logic [3:0] lanes);
    bus.btn = bus.btn | lanes;
    step(3);
    bus.btn = bus.btn & ~lanes;
    step(3);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step(1);
    check("judge_arrived", sb.size(), 0);
  endtask

  task automatic checkOutput_totals(input string tag);
    check({tag, "_score"}, bus.score, m_score);
    check({tag, "_combo"}, bus.combo, m_combo);
    check({tag, "_max"}, bus.max_combo, m_max);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.beat_tick = 1'b0; bus.sub_tick = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0;
    bus.arrow_mask = '0; bus.btn = '0;
    #12;
    check("rst_valid", bus.judge_valid, 0);
    check("rst_code", bus.judge_code, 0);
    check("rst_hits", {bus.correct_hit, bus.incorrect_hit}, 0);
    checkOutput_totals("rst");
    step(1);
    reset_n = 1'b1;
    step(2);

    // Single lane PERFECT at tick 1.
    applyStimulus_beat(4'b0001);
    subs(1);
    expect_judge(C_PERFECT);
    press(4'b0001);
    drain(8);
    check("t1_score", bus.score, 10);

    // Two lanes, completed at tick 5 -> GOOD.
    applyStimulus_beat(4'b0110);
    subs(2);
    press(4'b0010);
    subs(3);
    expect_judge(C_GOOD);
    press(4'b0100);
    drain(8);
    check("t2_score", bus.score, 15);

    // No press -> MISS when the 8th sub_tick lands.
    applyStimulus_beat(4'b1000);
    subs(7);
    expect_judge(C_MISS);
    subs(1);
    drain(4);

    // Press on unmasked lane -> WRONG; later correct press ignored.
    applyStimulus_beat(4'b0001);
    expect_judge(C_WRONG);
    press(4'b1000);
    drain(8);
    press(4'b0001);
    step(4);
    checkOutput_totals("t4");

    // Pause drops sub_ticks and a press that arrives during it.
    applyStimulus_beat(4'b0001);
    bus.pause = 1'b1;
    subs(8);
    bus.btn = 4'b0001;
    step(4);
    bus.pause = 1'b0;
    step(4);
    bus.btn = 4'b0000;
    step(3);
    expect_judge(C_PERFECT);
    press(4'b0001);
    drain(8);

    // Completion in the beat_tick cycle grades the old beat, new mask loads.
    applyStimulus_beat(4'b0010);
    subs(1);
    expect_judge(C_PERFECT);
    bus.btn = 4'b0010;
    step(2);
    bus.arrow_mask = 4'b0100;
    bus.beat_tick  = 1'b1;
    step(1);
    bus.beat_tick  = 1'b0;
    bus.btn        = 4'b0000;
    step(3);
    drain(4);
    expect_judge(C_PERFECT);
    press(4'b0100);
    drain(8);

    // Beat_tick with nothing pressed: old beat MISS, then a rest beat closes the window.
    applyStimulus_beat(4'b0001);
    expect_judge(C_MISS);
    applyStimulus_beat(4'b1000);
    drain(4);
    expect_judge(C_MISS);
    applyStimulus_beat(4'b0000);
    drain(4);
    press(4'b1000);
    step(4);

    // Clear colliding with a completing press: no judgement, totals zeroed.
    applyStimulus_beat(4'b0001);
    bus.btn = 4'b0001;
    step(2);
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    m_score = 0; m_combo = 0; m_max = 0;
    checkOutput_totals("clr");
    bus.btn = 4'b0000;
    step(3);
    press(4'b0001);
    step(4);

    // Twelve PERFECTs: bonus kicks in from the tenth hit.
    for (int i = 0; i < 12; i++) begin
      applyStimulus_beat(4'b0001);
      expect_judge(C_PERFECT);
      press(4'b0001);
      drain(8);
    end
    check("t5_score", bus.score, 123);
    check("t5_combo", bus.combo, 12);
    check("t5_max", bus.max_combo, 12);

    // Keep hitting until the score saturates, then once more.
    guard = 0;
    while (m_score < 9999 && guard < 2000) begin
      applyStimulus_beat(4'b0001);
      expect_judge(C_PERFECT);
      press(4'b0001);
      drain(8);
      guard++;
    end
    applyStimulus_beat(4'b0001);
    expect_judge(C_PERFECT);
    press(4'b0001);
    drain(8);
    check("sat_score", bus.score, 9999);

    // Async reset mid-window discards the beat.
    applyStimulus_beat(4'b0001);
    subs(1);
    bus.btn = 4'b0001;
    step(1);
    reset_n = 1'b0;
    #1;
    m_score = 0; m_combo = 0; m_max = 0;
    check("mid_rst_valid", bus.judge_valid, 0);
    check("mid_rst_hits", {bus.correct_hit, bus.incorrect_hit}, 0);
    check("mid_rst_code", bus.judge_code, 0);
    checkOutput_totals("mid_rst");
    step(3);
    bus.btn = 4'b0000;
    reset_n = 1'b1;
    step(4);
    checkOutput_totals("post_rst");

    applyStimulus_beat(4'b0001);
    expect_judge(C_PERFECT);
    press(4'b0001);
    drain(8);
    check("final_score", bus.score, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
